// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: IDLE accepts, EXEC captures alu_out, RESP holds the result.
module alu_arbiter #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [ILEN-1:0] req0_instr,
  input  logic [XLEN-1:0] req0_in1,
  input  logic [XLEN-1:0] req0_in2,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [ILEN-1:0] req1_instr,
  input  logic [XLEN-1:0] req1_in1,
  input  logic [XLEN-1:0] req1_in2,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [ILEN-1:0] alu_instr,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  input  logic [XLEN-1:0] alu_out,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q, owner_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] in1_q, in1_d;
  logic [XLEN-1:0] in2_q, in2_d;
  logic [XLEN-1:0] rsp_q, rsp_d;
  logic            grant;
  logic            any_valid;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    instr_d      = instr_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    rsp_d        = rsp_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    any_valid    = req0_valid | req1_valid;
    // On contention the requester that was not served last wins.
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;

    case (state_q)
      IDLE: begin
        // rst_n gating keeps ready low while reset is held.
        if (any_valid && !flush && rst_n) begin
          req0_ready   = ~grant;
          req1_ready   = grant;
          owner_d      = grant;
          last_grant_d = grant;
          instr_d      = grant ? req1_instr : req0_instr;
          in1_d        = grant ? req1_in1 : req0_in1;
          in2_d        = grant ? req1_in2 : req0_in2;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_d   = alu_out;
        state_d = RESP;
      end
      RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      rsp_d   = rsp_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      instr_q      <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
      rsp_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      instr_q      <= instr_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      rsp_q        <= rsp_d;
    end
  end

  assign alu_instr = instr_q;
  assign alu_in1   = in1_q;
  assign alu_in2   = in2_q;
  assign rsp_data  = rsp_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a tiny RV-style ALU model on the alu_* side, a vector
// table for single ops, hand-written sequences for contention, backpressure, flush and reset.
module tb_alu_arbiter;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [31:0] I_ADD  = 32'h0000_0033;
  localparam logic [31:0] I_SUB  = 32'h4000_0033;
  localparam logic [31:0] I_SLTU = 32'h0000_3033;
  localparam logic [31:0] I_XOR  = 32'h0000_4033;
  localparam logic [31:0] I_AND  = 32'h0000_7033;

  logic clk = 1'b0;
  logic rst_n, flush;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [ILEN-1:0] req0_instr, req1_instr;
  logic [XLEN-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [XLEN-1:0] rsp_data, alu_in1, alu_in2, alu_out;
  logic [ILEN-1:0] alu_instr;
  logic busy;

  logic [XLEN-1:0] exp0, exp1;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic            port;
    logic [XLEN-1:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct packed {
    logic            port;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] alu_fn(input logic [ILEN-1:0] ins,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    case (ins[14:12])
      3'b000:  return ins[30] ? a - b : a + b;
      3'b011:  return {{(XLEN-1){1'b0}}, (a < b)};
      3'b100:  return a ^ b;
      3'b111:  return a & b;
      default: return '0;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_instr, alu_in1, alu_in2);

  alu_arbiter #(.XLEN(XLEN), .ILEN(ILEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr),
    .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr),
    .req1_in1(req1_in1), .req1_in2(req1_in2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .alu_instr(alu_instr), .alu_in1(alu_in1),
    .alu_in2(alu_in2), .alu_out(alu_out), .busy(busy)
  );

  function automatic void chk(input string name, input logic [XLEN-1:0] act,
                              input logic [XLEN-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endfunction

  // Scoreboard: push at request handshake, pop and compare at response handshake.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) sb_q.delete();
    else if (flush && busy) sb_q.delete();
    else begin
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_rsp: got rsp0_valid=%0b rsp1_valid=%0b required none", rsp0_valid, rsp1_valid);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_port", {{(XLEN-1){1'b0}}, rsp1_valid}, {{(XLEN-1){1'b0}}, e.port});
          chk("rsp_data", rsp_data, e.data);
          $display("[TB] rsp port %0d data %h expected %h", rsp1_valid, rsp_data, e.data);
        end
      end
      if (req0_valid && req0_ready) sb_q.push_back({1'b0, exp0});
      if (req1_valid && req1_ready) sb_q.push_back({1'b1, exp1});
    end
  end

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic port, input logic [ILEN-1:0] ins,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] e);
    if (port) begin
      req1_valid = 1'b1; req1_instr = ins; req1_in1 = a; req1_in2 = b; exp1 = e;
    end else begin
      req0_valid = 1'b1; req0_instr = ins; req0_in1 = a; req0_in2 = b; exp0 = e;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    sample();
    while (busy && k < 20) begin
      next_cyc();
      sample();
      k++;
    end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
    next_cyc();
  endtask

  task automatic run_vec(input vec_t v);
    set_req(v.port, v.instr, v.a, v.b, v.exp);
    sample();
    chk("vec_ready", {63'd0, v.port ? req1_ready : req0_ready}, 64'd1);
    chk("vec_other_ready", {63'd0, v.port ? req0_ready : req1_ready}, 64'd0);
    next_cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sample();
    chk("vec_exec_busy", {63'd0, busy}, 64'd1);
    chk("vec_exec_norsp", {63'd0, rsp0_valid | rsp1_valid}, 64'd0);
    chk("vec_alu_in1", alu_in1, v.a);
    chk("vec_alu_instr", {32'd0, alu_instr}, {32'd0, v.instr});
    next_cyc();
    sample();
    chk("vec_rsp_valid_t2", {63'd0, v.port ? rsp1_valid : rsp0_valid}, 64'd1);
    next_cyc();
    sample();
    chk("vec_idle_after", {63'd0, busy}, 64'd0);
    next_cyc();
  endtask

  initial begin
    int order[$];
    vecs[0] = '{1'b0, I_ADD,  64'd5,  64'd3, 64'd8};
    vecs[1] = '{1'b1, I_SUB,  64'd10, 64'd3, 64'd7};
    vecs[2] = '{1'b0, I_SLTU, 64'd3,  64'd5, 64'd1};
    vecs[3] = '{1'b1, I_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    vecs[4] = '{1'b0, I_XOR,  64'h00FF_00FF_00FF_00FF, 64'hFFFF_0000_FFFF_0000, 64'hFF00_00FF_FF00_00FF};
    vecs[5] = '{1'b1, I_AND,  64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001};

    rst_n = 1'b1; flush = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_instr = I_ADD; req1_instr = I_ADD;
    req0_in1 = '0; req0_in2 = '0; req1_in1 = '0; req1_in2 = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    exp0 = '0; exp1 = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
    chk("rst_req1_ready", {63'd0, req1_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp0_valid | rsp1_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_alu_in1", alu_in1, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("idle_no_rsp", {63'd0, rsp0_valid | rsp1_valid | busy}, 64'd0);
      next_cyc();
    end

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Both valid continuously: grants alternate starting with req0.
    set_req(1'b0, I_SUB,  64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE);
    set_req(1'b1, I_SLTU, 64'd3, 64'd5, 64'd1);
    for (int c = 0; c < 9; c++) begin
      sample();
      if (req0_ready) order.push_back(0);
      if (req1_ready) order.push_back(1);
      next_cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_grant_count", 64'(order.size()), 64'd3);
    if (order.size() == 3) begin
      chk("rr_grant0", 64'(order[0]), 64'd0);
      chk("rr_grant1", 64'(order[1]), 64'd1);
      chk("rr_grant2", 64'(order[2]), 64'd0);
    end
    wait_idle();

    // Response backpressure on port 1 with req0 pending.
    rsp1_ready = 1'b0;
    set_req(1'b1, I_ADD, 64'd2, 64'd2, 64'd4);
    sample();
    chk("bp_accept1", {63'd0, req1_ready}, 64'd1);
    next_cyc();
    req1_valid = 1'b0;
    set_req(1'b0, I_ADD, 64'd1, 64'd1, 64'd2);
    sample();
    chk("bp_exec_no_accept", {63'd0, req0_ready}, 64'd0);
    next_cyc();
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("bp_rsp1_valid", {63'd0, rsp1_valid}, 64'd1);
      chk("bp_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
      chk("bp_data_stable", rsp_data, 64'd4);
      chk("bp_req0_held", {63'd0, req0_ready}, 64'd0);
      next_cyc();
    end
    rsp1_ready = 1'b1;
    sample();
    chk("bp_rsp1_handshake", {63'd0, rsp1_valid}, 64'd1);
    next_cyc();
    sample();
    chk("bp_req0_accept", {63'd0, req0_ready}, 64'd1);
    next_cyc();
    req0_valid = 1'b0;
    wait_idle();

    // Flush during EXEC drops the op; flush in IDLE blocks an accept.
    set_req(1'b0, I_ADD, 64'd7, 64'd7, 64'd14);
    sample();
    chk("fl_accept", {63'd0, req0_ready}, 64'd1);
    next_cyc();
    req0_valid = 1'b0;
    flush = 1'b1;
    sample();
    chk("fl_exec_busy", {63'd0, busy}, 64'd1);
    next_cyc();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("fl_idle", {63'd0, busy}, 64'd0);
      chk("fl_no_rsp", {63'd0, rsp0_valid | rsp1_valid}, 64'd0);
      next_cyc();
    end
    flush = 1'b1;
    set_req(1'b1, I_ADD, 64'd9, 64'd1, 64'd10);
    sample();
    chk("fl_blocks_accept", {63'd0, req1_ready}, 64'd0);
    next_cyc();
    flush = 1'b0;
    sample();
    chk("fl_busy_after_block", {63'd0, busy}, 64'd0);
    chk("fl_next_accept", {63'd0, req1_ready}, 64'd1);
    next_cyc();
    req1_valid = 1'b0;
    wait_idle();

    // Async reset while holding a response; last_grant returns to 1.
    rsp0_ready = 1'b0;
    set_req(1'b0, I_ADD, 64'd1, 64'd2, 64'd3);
    sample();
    chk("rr_accept", {63'd0, req0_ready}, 64'd1);
    next_cyc();
    req0_valid = 1'b0;
    next_cyc();
    sample();
    chk("rr_hold_valid", {63'd0, rsp0_valid}, 64'd1);
    next_cyc();
    rst_n = 1'b0;
    #2;
    chk("rr_valid_drop", {63'd0, rsp0_valid}, 64'd0);
    chk("rr_busy_drop", {63'd0, busy}, 64'd0);
    chk("rr_data_clear", rsp_data, 64'd0);
    set_req(1'b0, I_ADD, 64'd1, 64'd2, 64'd3);
    set_req(1'b1, I_ADD, 64'd2, 64'd2, 64'd4);
    #1;
    chk("rr_ready_in_reset", {63'd0, req0_ready | req1_ready}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    sample();
    chk("rr_first_grant0", {63'd0, req0_ready}, 64'd1);
    chk("rr_first_not1", {63'd0, req1_ready}, 64'd0);
    next_cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

endmodule
